cassette_rec: RTL and testbench
===============================

// Module: cassette_rec
// PURPOSE
//  Tape recorder: the capture counterpart of cassette playback. Decodes the Oric
//  cassette-out square wave into bits by period measurement, packs 8 bits per byte
//  and writes bytes sequentially to SDRAM from address 0. tape_end reports the
//  recorded length so the image can be replayed or saved.
// PARAMETERS
//  THRESH      15000   period (clk cycles) below which a bit decodes as 1, else 0
//  MIN_PERIOD  2000    periods shorter than this are glitches; edge ignored
//  TIMEOUT     60000   no accepted edge for this many cycles -> partial byte dropped
//  MAX_ADDR    25'h1FFFFFF  last writable SDRAM address
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous reset, active low
//  en           in   1   record enable (level)
//  rewind       in   1   sync clear of address/length/flags (level, dominant)
//  tape_in      in   1   raw cassette-out signal, asynchronous
//  sdram_addr   out  25  write address
//  sdram_dout   out  8   write data
//  sdram_wr     out  1   write request, held until acknowledged
//  sdram_ack    in   1   write accepted (1-cycle pulse)
//  tape_end     out  25  bytes written (address of next write)
//  status       out  3   {full, overflow, recording}
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; shift reg, bit count, period counter cleared.
//  Input: tape_in through 2-flop synchroniser; rising edge of synced value = edge.
//  Main FSM: IDLE -> (en=1) ARM -> (first edge) RUN; any state -> (en=0) IDLE;
//   RUN -> FULL when a write to MAX_ADDR is acked. FULL holds until rewind.
//   recording = (state==ARM || state==RUN).
//  ARM: first edge only starts period counter (no bit); bit count = 0.
//  RUN: period counter counts cycles since last accepted edge, saturates at TIMEOUT.
//   Edge with P < MIN_PERIOD: ignored, counter keeps running.
//   Edge with MIN_PERIOD <= P < TIMEOUT: bit = (P < THRESH); shift in MSB-first
//   (first bit -> sdram_dout[7]); counter restarts.
//   Counter reaches TIMEOUT: partial bits discarded, bit count = 0, back to ARM.
//  Byte complete (8th bit): on next cycle, if no write pending, byte -> sdram_dout,
//   sdram_wr=1; if write pending, byte dropped and overflow set (sticky).
//   Capture continues during a pending write.
//  Write handshake: sdram_wr, sdram_addr, sdram_dout stable until sdram_ack=1;
//   cycle after ack: sdram_wr=0, sdram_addr+1, tape_end=new sdram_addr.
//   ack while sdram_wr=0 is ignored.
//  en falls: partial byte discarded; pending write still completes; then IDLE.
//  rewind=1: sdram_addr=0, tape_end=0, overflow=0, full=0, sdram_wr=0, state IDLE;
//   overrides ack/byte completion in the same cycle.
//  Address never wraps: in FULL no further writes issue.
//  Reset mid-write drops the request immediately; no ack expected afterwards.
// TESTING
//  1 reset_n low with toggling tape_in -> all outputs 0, status=0, no sdram_wr.
//  2 en=1, edge, periods 10000/20000 for bits 1,0,1,0,0,1,1,0 -> one write
//    data 8'hA6 at addr 0, ack -> tape_end=1, status=3'b001.
//  3 ack delayed 5 cycles -> sdram_wr/addr/dout stable for all 5; one increment.
//  4 60-cycle glitch pulse mid-period of a 20000 bit -> still decodes 0, byte intact.
//  5 3 bits then silence 60000 -> no write, bit count 0, FSM back to ARM; next
//    8 bits of 1 -> 8'hFF at addr 0.
//  6 ack withheld while second byte completes -> overflow=1, second byte absent;
//    rewind -> addr=0, tape_end=0, status=3'b000.

Source files
------------

// File: rtl/cassette_rec_if.sv
`default_nettype none
// ============================================================================
// Module      : cassette_rec_if
// Description : SDRAM byte-write port of the tape recorder (request/ack).
// Revision    : 1.0 - initial release
// ============================================================================
interface cassette_rec_if;
  logic [24:0] sdram_addr;
  logic [7:0]  sdram_dout;
  logic        sdram_wr;
  logic        sdram_ack;

  modport master (
    output sdram_addr,
    output sdram_dout,
    output sdram_wr,
    input  sdram_ack
  );

  modport slave (
    input  sdram_addr,
    input  sdram_dout,
    input  sdram_wr,
    output sdram_ack
  );
endinterface
`default_nettype wire

// File: rtl/cassette_rec.sv
`default_nettype none
// ============================================================================
// Module      : cassette_rec
// Description : Oric cassette-out decoder; period-measured bits packed MSB-first
//               into bytes and written sequentially to SDRAM from address 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cassette_rec #(
  parameter int unsigned THRESH     = 15000,
  parameter int unsigned MIN_PERIOD = 2000,
  parameter int unsigned TIMEOUT    = 60000,
  parameter logic [24:0] MAX_ADDR   = 25'h1FFFFFF
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_i,
  input  logic           rewind_i,
  input  logic           tape_in_i,
  cassette_rec_if.master sdram_if,
  output logic [24:0]    tape_end_o,
  output logic [2:0]     status_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_THRESH  = CW'(THRESH);
  localparam logic [CW-1:0] C_MIN     = CW'(MIN_PERIOD);
  localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_FULL = 2'd3
  } state_t;

  state_t        state_q;
  logic          tape_meta_q;
  logic          tape_sync_q;
  logic          tape_prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bitcnt_q;
  logic [6:0]    shift_q;
  logic [24:0]   addr_q;
  logic [7:0]    dout_q;
  logic          wr_q;
  logic [24:0]   tape_end_q;
  logic          ovf_q;
  logic          full_q;

  logic          w_edge;
  logic          w_bit;
  logic [7:0]    w_byte;
  logic          w_ack;
  logic          w_ack_last;
  logic          w_timeout;
  logic          w_accept;
  logic          w_recording;

  assign w_edge      = tape_sync_q & ~tape_prev_q;
  assign w_bit       = (cnt_q < C_THRESH);
  assign w_byte      = {shift_q, w_bit};
  assign w_ack       = wr_q & sdram_if.sdram_ack;
  assign w_ack_last  = w_ack && (addr_q == MAX_ADDR);
  assign w_timeout   = (cnt_q >= C_TIMEOUT);
  assign w_accept    = w_edge && (cnt_q >= C_MIN) && !w_timeout;
  assign w_recording = (state_q == S_ARM) || (state_q == S_RUN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      tape_meta_q <= 1'b0;
      tape_sync_q <= 1'b0;
      tape_prev_q <= 1'b0;
      cnt_q       <= '0;
      bitcnt_q    <= 3'd0;
      shift_q     <= 7'd0;
      addr_q      <= 25'd0;
      dout_q      <= 8'd0;
      wr_q        <= 1'b0;
      tape_end_q  <= 25'd0;
      ovf_q       <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      tape_meta_q <= tape_in_i;
      tape_sync_q <= tape_meta_q;
      tape_prev_q <= tape_sync_q;

      if (rewind_i) begin
        state_q    <= S_IDLE;
        cnt_q      <= '0;
        bitcnt_q   <= 3'd0;
        shift_q    <= 7'd0;
        addr_q     <= 25'd0;
        wr_q       <= 1'b0;
        tape_end_q <= 25'd0;
        ovf_q      <= 1'b0;
        full_q     <= 1'b0;
      end else begin
        // The last address is never stepped past, so tape_end saturates there too.
        if (w_ack) begin
          wr_q <= 1'b0;
          if (w_ack_last) begin
            full_q <= 1'b1;
          end else begin
            addr_q     <= addr_q + 25'd1;
            tape_end_q <= addr_q + 25'd1;
          end
        end

        case (state_q)
          S_IDLE: begin
            cnt_q    <= '0;
            bitcnt_q <= 3'd0;
            if (en_i && !full_q) begin
              state_q <= S_ARM;
            end
          end
          S_ARM: begin
            bitcnt_q <= 3'd0;
            if (!en_i) begin
              state_q <= S_IDLE;
            end else if (w_edge) begin
              state_q <= S_RUN;
              cnt_q   <= CW'(1);
            end
          end
          S_RUN: begin
            if (!en_i) begin
              state_q  <= S_IDLE;
              cnt_q    <= '0;
              bitcnt_q <= 3'd0;
            end else if (w_timeout) begin
              state_q  <= S_ARM;
              cnt_q    <= '0;
              bitcnt_q <= 3'd0;
            end else if (w_accept) begin
              cnt_q   <= CW'(1);
              shift_q <= w_byte[6:0];
              if (bitcnt_q == 3'd7) begin
                bitcnt_q <= 3'd0;
                if (wr_q) begin
                  ovf_q <= 1'b1;
                end else begin
                  dout_q <= w_byte;
                  wr_q   <= 1'b1;
                end
              end else begin
                bitcnt_q <= bitcnt_q + 3'd1;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_FULL: begin
            state_q <= S_FULL;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase

        if (w_ack_last) begin
          state_q <= S_FULL;
        end
      end
    end
  end

  assign sdram_if.sdram_addr = addr_q;
  assign sdram_if.sdram_dout = dout_q;
  assign sdram_if.sdram_wr   = wr_q;
  assign tape_end_o          = tape_end_q;
  assign status_o            = {full_q, ovf_q, w_recording};

endmodule
`default_nettype wire

// File: tb/tb_cassette_rec.sv
`default_nettype none
// ============================================================================
// Module      : tb_cassette_rec
// Description : Self-checking bench for cassette_rec (scaled-down timing).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cassette_rec;
  localparam int          THRESH = 150;
  localparam int          MINP   = 20;
  localparam int          TOUT   = 600;
  localparam logic [24:0] MAXA   = 25'd9;

  typedef struct packed {
    logic [7:0] pat;
    logic [9:0] p1;
    logic [9:0] p0;
    logic [2:0] dly;
    logic [7:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rewind;
  logic        tape_in;
  logic [24:0] tape_end;
  logic [2:0]  status;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          ack_dly = 0;
  bit          ack_en = 1'b1;
  int          edges[$];
  logic [32:0] wr_log[$];
  logic [7:0]  exp_bytes[$];
  vec_t        vt[6];

  cassette_rec_if sif();

  cassette_rec #(
    .THRESH     (THRESH),
    .MIN_PERIOD (MINP),
    .TIMEOUT    (TOUT),
    .MAX_ADDR   (MAXA)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .rewind_i   (rewind),
    .tape_in_i  (tape_in),
    .sdram_if   (sif.master),
    .tape_end_o (tape_end),
    .status_o   (status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SDRAM model: acks after ack_dly cycles, logs each accepted write.
  initial begin : responder
    int          wcnt;
    logic [24:0] a0;
    logic [7:0]  d0;
    wcnt = 0;
    a0 = '0;
    d0 = '0;
    sif.sdram_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (sif.sdram_ack) begin
        sif.sdram_ack = 1'b0;
        wcnt = 0;
      end else if (sif.sdram_wr && ack_en) begin
        if (wcnt == 0) begin
          a0 = sif.sdram_addr;
          d0 = sif.sdram_dout;
        end else begin
          chk("hold_addr", 32'(sif.sdram_addr), 32'(a0));
          chk("hold_data", 32'(sif.sdram_dout), 32'(d0));
        end
        if (wcnt >= ack_dly) begin
          sif.sdram_ack = 1'b1;
          wr_log.push_back({a0, d0});
        end
        wcnt++;
      end else if (!sif.sdram_wr) begin
        wcnt = 0;
      end
    end
  end

  task automatic drive_period(input int p, input bit glitch);
    tape_in = 1'b1;
    edges.push_back(cyc);
    if (glitch) begin
      tick(5);
      tape_in = 1'b0;
      tick(3);
      tape_in = 1'b1;
      edges.push_back(cyc);
      tick(p / 2 - 8);
    end else begin
      tick(p / 2);
    end
    tape_in = 1'b0;
    tick(p - p / 2);
  endtask

  task automatic final_edge();
    tape_in = 1'b1;
    edges.push_back(cyc);
    tick(4);
    tape_in = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] pat, input int p1, input int p0, input logic [7:0] gm);
    for (int b = 7; b >= 0; b--) begin
      drive_period(pat[b] ? p1 : p0, gm[b]);
    end
    final_edge();
  endtask

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while ((wr_log.size() < n || sif.sdram_wr) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("write_seen", 32'(k < 200), 32'd1);
  endtask

  task automatic do_rewind();
    en = 1'b0;
    rewind = 1'b1;
    tick(2);
    rewind = 1'b0;
    en = 1'b1;
    tick(3);
  endtask

  // Reference: walk rising-edge times and apply the decoding rules directly.
  task automatic build_model();
    bit         armed;
    int         last;
    int         n;
    int         dt;
    logic [7:0] acc;
    armed = 1'b1;
    last = 0;
    n = 0;
    acc = '0;
    exp_bytes.delete();
    foreach (edges[i]) begin
      dt = edges[i] - last;
      if (armed || dt >= TOUT) begin
        armed = 1'b0;
        last = edges[i];
        n = 0;
      end else if (dt >= MINP) begin
        acc = {acc[6:0], (dt < THRESH) ? 1'b1 : 1'b0};
        last = edges[i];
        n++;
        if (n == 8) begin
          n = 0;
          if (exp_bytes.size() <= int'(MAXA)) exp_bytes.push_back(acc);
        end
      end
    end
  endtask

  initial begin
    bit full;
    vt[0] = '{pat: 8'hA6, p1: 10'd100, p0: 10'd200, dly: 3'd0, exp: 8'hA6};
    vt[1] = '{pat: 8'h3C, p1: 10'd149, p0: 10'd150, dly: 3'd5, exp: 8'h3C};
    vt[2] = '{pat: 8'h81, p1: 10'd20,  p0: 10'd599, dly: 3'd1, exp: 8'h81};
    vt[3] = '{pat: 8'hFF, p1: 10'd100, p0: 10'd200, dly: 3'd2, exp: 8'hFF};
    vt[4] = '{pat: 8'h00, p1: 10'd100, p0: 10'd200, dly: 3'd3, exp: 8'h00};
    vt[5] = '{pat: 8'h5A, p1: 10'd40,  p0: 10'd400, dly: 3'd4, exp: 8'h5A};

    rst_n = 1'b0;
    en = 1'b0;
    rewind = 1'b0;
    tape_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tape_in = i[0];
      tick(1);
    end
    chk("rst_wr", 32'(sif.sdram_wr), 32'd0);
    chk("rst_addr", 32'(sif.sdram_addr), 32'd0);
    chk("rst_dout", 32'(sif.sdram_dout), 32'd0);
    chk("rst_tape_end", 32'(tape_end), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    tape_in = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("idle_status", 32'(status), 32'd0);
    en = 1'b1;
    tick(3);
    chk("arm_status", 32'(status), 32'd1);

    for (int i = 0; i < 6; i++) begin
      ack_dly = int'(vt[i].dly);
      drive_byte(vt[i].pat, int'(vt[i].p1), int'(vt[i].p0), 8'h00);
      wait_log(i + 1);
      if (wr_log.size() > i) begin
        chk("vec_addr", 32'(wr_log[i][32:8]), 32'(i));
        chk("vec_data", 32'(wr_log[i][7:0]), 32'(vt[i].exp));
      end
      chk("vec_tape_end", 32'(tape_end), 32'(i + 1));
      chk("vec_status", 32'(status), 32'd1);
      tick(TOUT + 20);
    end

    ack_dly = 1;
    drive_byte(8'h69, 100, 200, 8'b1001_0110);
    wait_log(7);
    if (wr_log.size() > 6) chk("glitch_data", 32'(wr_log[6][7:0]), 32'h69);
    chk("glitch_tape_end", 32'(tape_end), 32'd7);
    tick(TOUT + 20);

    do_rewind();
    wr_log.delete();
    for (int i = 0; i < 3; i++) drive_period(100, 1'b0);
    final_edge();
    tick(TOUT + 100);
    chk("to_no_write", 32'(wr_log.size()), 32'd0);
    chk("to_status", 32'(status), 32'd1);
    chk("to_tape_end", 32'(tape_end), 32'd0);
    drive_byte(8'hFF, 100, 200, 8'h00);
    wait_log(1);
    if (wr_log.size() > 0) begin
      chk("to_addr", 32'(wr_log[0][32:8]), 32'd0);
      chk("to_data", 32'(wr_log[0][7:0]), 32'hFF);
    end
    tick(TOUT + 20);

    do_rewind();
    wr_log.delete();
    ack_en = 1'b0;
    drive_byte(8'h12, 100, 200, 8'h00);
    tick(TOUT + 20);
    drive_byte(8'h34, 100, 200, 8'h00);
    tick(10);
    chk("ovf_status", 32'(status), 32'b011);
    chk("ovf_wr_held", 32'(sif.sdram_wr), 32'd1);
    chk("ovf_dout", 32'(sif.sdram_dout), 32'h12);
    chk("ovf_addr", 32'(sif.sdram_addr), 32'd0);
    ack_en = 1'b1;
    wait_log(1);
    tick(20);
    chk("ovf_writes", 32'(wr_log.size()), 32'd1);
    chk("ovf_tape_end", 32'(tape_end), 32'd1);
    en = 1'b0;
    tick(2);
    rewind = 1'b1;
    tick(1);
    chk("rew_addr", 32'(sif.sdram_addr), 32'd0);
    chk("rew_tape_end", 32'(tape_end), 32'd0);
    chk("rew_status", 32'(status), 32'd0);
    rewind = 1'b0;
    tick(2);

    do_rewind();
    wr_log.delete();
    edges.delete();
    for (int k = 0; k < 140; k++) begin
      int r;
      int p;
      r = int'($urandom_range(0, 99));
      ack_dly = int'($urandom_range(0, 4));
      if (r < 4) begin
        tick(TOUT + 100);
      end else begin
        if ($urandom_range(0, 1) == 1) p = int'($urandom_range(40, 140));
        else p = int'($urandom_range(160, 350));
        drive_period(p, r < 12);
      end
    end
    final_edge();
    tick(60);
    build_model();
    chk("rnd_count", 32'(wr_log.size()), 32'(exp_bytes.size()));
    foreach (exp_bytes[i]) begin
      if (i < wr_log.size()) begin
        chk("rnd_addr", 32'(wr_log[i][32:8]), 32'(i));
        chk("rnd_data", 32'(wr_log[i][7:0]), 32'(exp_bytes[i]));
      end
    end
    full = (exp_bytes.size() == int'(MAXA) + 1);
    chk("rnd_status", 32'(status), 32'({full, 1'b0, ~full}));
    chk("rnd_tape_end", 32'(tape_end), full ? 32'(MAXA) : 32'(exp_bytes.size()));

    do_rewind();
    ack_en = 1'b0;
    drive_byte(8'h5A, 100, 200, 8'h00);
    tick(5);
    chk("rmw_wr_before", 32'(sif.sdram_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmw_wr_dropped", 32'(sif.sdram_wr), 32'd0);
    chk("rmw_status", 32'(status), 32'd0);
    tick(3);
    ack_en = 1'b1;
    en = 1'b0;
    rst_n = 1'b1;
    tick(20);
    chk("rmw_wr_after", 32'(sif.sdram_wr), 32'd0);
    chk("rmw_tape_end", 32'(tape_end), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
